// File: rtl/mysystem_data_out32b_stream.sv
// mysystem_data_out32b_stream
//   Avalon-MM slave that queues CPU-written 32-bit words in a FIFO and hands
//   them to fabric logic over a valid/ready stream. Transmit-side companion of
//   the 32-bit input PIO: the CPU pushes, the fabric pops.
//
// Ports
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   address[1:0]            register select
//   chipselect, write_n     write strobe = chipselect & ~write_n
//   writedata[31:0]         write data
//   readdata[31:0]          registered read data (1-cycle latency)
//   irq                     |(event & irq_mask)
//   out_port[31:0]          stream data (FIFO head)
//   out_valid, out_ready    stream handshake
//
// Register map
//   0  W: push writedata        R: FIFO head (0 when empty)
//   1  W: bit0=1 flushes FIFO   R: {16'b0, level[7:0], 5'b0, lowwm, full, empty}
//   2  R/W: irq_mask[2:0]
//   3  R: event {overflow, lowwm, drained}   W: write-1-to-clear
//
// Build option
//   DATA_OUT_HOLD_LAST_EN : when empty, out_port holds the last popped word
//                           (0 after reset or flush). Otherwise out_port is
//                           forced to 0 whenever out_valid is low.

module mysystem_data_out32b_stream #(
  parameter int DEPTH_LOG2 = 4,
  parameter int LOW_WM     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [31:0] out_port,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0]         FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]         LOWWM_CNT = CW'(LOW_WM);
  localparam logic [CW-1:0]         ONE_CNT   = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  // Storage and state
  logic [31:0]           mem_q [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]            event_q, event_d;
  logic [2:0]            irq_mask_q, irq_mask_d;
  logic [31:0]           readdata_q, readdata_d;

  // Decoded strobes
  logic        wr_s;
  logic        push_req_s;
  logic        drop_s;
  logic        push_s;
  logic        pop_s;
  logic        flush_s;
  logic        valid_s;
  logic [31:0] head_s;
  logic [31:0] status_s;
  logic [2:0]  ev_set_s;
  logic [2:0]  ev_clr_s;

  // Bus decode and stream handshake qualification
  always_comb begin
    wr_s       = chipselect & ~write_n;
    valid_s    = (count_q != '0);
    push_req_s = wr_s & (address == 2'd0);
    // Fullness is judged on the registered count, so a same-cycle pop does
    // not make room for a push into a full FIFO.
    drop_s     = push_req_s & (count_q == FULL_CNT);
    push_s     = push_req_s & ~drop_s;
    pop_s      = valid_s & out_ready;
    flush_s    = wr_s & (address == 2'd1) & writedata[0];
    head_s     = valid_s ? mem_q[rd_ptr_q] : 32'h0;
    status_s   = {16'h0, 8'(count_q), 5'b0_0000,
                  (count_q < LOWWM_CNT), (count_q == FULL_CNT), ~valid_s};
  end

  // FIFO pointer and count next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (flush_s) begin
      // Push and flush use different addresses, so wr_ptr is stable here.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  // Event capture, mask register and read mux next-state
  always_comb begin
    // Level-crossing events only count pops that actually change the level,
    // and a flush never reports them.
    ev_set_s[2] = drop_s;
    ev_set_s[1] = pop_s & ~push_s & ~flush_s & (count_q == LOWWM_CNT);
    ev_set_s[0] = pop_s & ~push_s & ~flush_s & (count_q == ONE_CNT);
    if (wr_s && (address == 2'd3)) begin
      ev_clr_s = writedata[2:0];
    end else begin
      ev_clr_s = 3'b000;
    end
    // Clear wins over a same-cycle set.
    event_d = (event_q | ev_set_s) & ~ev_clr_s;

    if (wr_s && (address == 2'd2)) begin
      irq_mask_d = writedata[2:0];
    end else begin
      irq_mask_d = irq_mask_q;
    end

    case (address)
      2'd0:    readdata_d = head_s;
      2'd1:    readdata_d = status_s;
      2'd2:    readdata_d = {29'h0, irq_mask_q};
      2'd3:    readdata_d = {29'h0, event_q};
      default: readdata_d = 32'h0;
    endcase
  end

  // Control and register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      event_q    <= 3'b000;
      irq_mask_q <= 3'b000;
      readdata_q <= 32'h0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      event_q    <= event_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
    end
  end

  // FIFO storage; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= writedata;
    end
  end

`ifdef DATA_OUT_HOLD_LAST_EN
  logic [31:0] last_q, last_d;

  // Last-popped word, cleared by flush so an emptied FIFO shows 0
  always_comb begin
    if (flush_s) begin
      last_d = 32'h0;
    end else if (pop_s) begin
      last_d = mem_q[rd_ptr_q];
    end else begin
      last_d = last_q;
    end
  end

  // Last-popped word register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 32'h0;
    end else begin
      last_q <= last_d;
    end
  end

  assign out_port = valid_s ? mem_q[rd_ptr_q] : last_q;
`else
  assign out_port = head_s;
`endif

  assign out_valid = valid_s;
  assign readdata  = readdata_q;
  assign irq       = |(event_q & irq_mask_q);

endmodule
